// File: rtl/rk8e_pkg.sv
// rk8e_pkg: shared definitions for the RK8E transfer sequencer.
//   - op_e        : RK8E function codes (cmd[0:2])
//   - ST_*        : err_status / status register bit indices (PDP-8 numbering, bit 0 = MSB)
//   - seq_state_e : sequencer state encoding
//   - MAX_CYL_DEF : default highest legal cylinder
package rk8e_pkg;

    localparam int MAX_CYL_DEF = 203;

    typedef enum logic [2:0] {
        OP_READ      = 3'd0,
        OP_READ_ALL  = 3'd1,
        OP_WPROT     = 3'd2,
        OP_SEEK      = 3'd3,
        OP_WRITE     = 3'd4,
        OP_WRITE_ALL = 3'd5
    } op_e;

    localparam int ST_BUSY   = 0;
    localparam int ST_TIMING = 6;
    localparam int ST_WLOCK  = 7;
    localparam int ST_DRIVE  = 10;
    localparam int ST_CYL    = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_ISSUE = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } seq_state_e;

endpackage

// File: rtl/rk8e_op_check.sv
// rk8e_op_check: combinational CHECK-stage decode.
// Ports:
//   op         in  [2:0]  latched function code
//   cyl        in  [7:0]  latched cylinder {cmd[11],dar[0:6]}
//   locked     in  1      write-lock flag of the addressed drive
//   next_state out        S_ISSUE when an SD access is needed, else S_DONE
//   err_set    out [0:11] error bits to OR into err_status
//   set_lock   out 1      set write_lock of the addressed drive
// Checks are prioritised: cylinder range, illegal function, write-protect,
// seek, locked write, then SD access.
module rk8e_op_check
    import rk8e_pkg::*;
#(
    parameter int MAX_CYL = MAX_CYL_DEF
) (
    input  logic [2:0]  op,
    input  logic [7:0]  cyl,
    input  logic        locked,
    output seq_state_e  next_state,
    output logic [0:11] err_set,
    output logic        set_lock
);

    localparam logic [7:0] MAX_CYL_V = 8'(MAX_CYL);

    always_comb begin
        next_state = S_DONE;
        err_set    = '0;
        set_lock   = 1'b0;
        if (cyl > MAX_CYL_V) begin
            err_set[ST_CYL] = 1'b1;
        end else if (op == 3'd6 || op == 3'd7) begin
            err_set[ST_DRIVE] = 1'b1;
        end else if (op == OP_WPROT) begin
            set_lock = 1'b1;
        end else if (op == OP_SEEK) begin
            // seek is a local operation: nothing to do on the card
        end else if ((op == OP_WRITE || op == OP_WRITE_ALL) && locked) begin
            err_set[ST_WLOCK] = 1'b1;
        end else begin
            next_state = S_ISSUE;
        end
    end

endmodule

// File: rtl/rk8e_xfer_seq.sv
// rk8e_xfer_seq: RK8E command sequencer between the register file and the
// SD-card sector engine. Latches a command on go, validates it, issues one
// SD operation and reports busy/done/error status.
// Optional feature macro: RK8E_WATCHDOG_EN (WAIT-state timeout, sets bit 6).
// Ports:
//   clk, reset_n (async active-low), clear (sync abort, same as reset)
//   go             DLAG pulse; accepted only in IDLE
//   cmd/dar/car    RK8E command, disk-address, current-address registers
//   sd_busy/sd_done/sd_err  SD engine status
//   sd_go          one-cycle strobe (ISSUE with sd_busy low)
//   sd_op/sd_mem_addr/sd_disk_addr/sd_len  from holding registers
//   busy, done_pulse, err_status[0:11], write_lock[0:3]
module rk8e_xfer_seq
    import rk8e_pkg::*;
#(
    parameter int              MAX_CYL  = MAX_CYL_DEF,
    parameter int              TO_W     = 24,
    parameter logic [TO_W-1:0] TO_LIMIT = '1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        go,
    input  logic [0:11] cmd,
    input  logic [0:11] dar,
    input  logic [0:11] car,
    input  logic        sd_busy,
    input  logic        sd_done,
    input  logic        sd_err,
    output logic        sd_go,
    output logic [0:2]  sd_op,
    output logic [0:14] sd_mem_addr,
    output logic [0:14] sd_disk_addr,
    output logic        sd_len,
    output logic        busy,
    output logic        done_pulse,
    output logic [0:11] err_status,
    output logic [0:3]  write_lock
);

    seq_state_e  state, state_next, chk_next;
    logic [0:2]  hold_op;
    logic [0:14] hold_mem;
    logic [0:14] hold_disk;
    logic        hold_len;
    logic [0:11] chk_err;
    logic        chk_set_lock;
    logic [1:0]  drive;
    logic        wd_timeout;
    logic [1:0]  cmd_unused;

    assign cmd_unused = cmd[3:4];
    // hold_disk = {drive[0:1], cmd[11], dar[0:11]}
    assign drive = hold_disk[0:1];

    rk8e_op_check #(.MAX_CYL(MAX_CYL)) u_check (
        .op         (hold_op),
        .cyl        (hold_disk[2:9]),
        .locked     (write_lock[drive]),
        .next_state (chk_next),
        .err_set    (chk_err),
        .set_lock   (chk_set_lock)
    );

`ifdef RK8E_WATCHDOG_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_LIMIT - 1'b1;
    logic [TO_W-1:0] wd_cnt;

    // Counts WAIT cycles; restarted while in ISSUE so it is zero on WAIT entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_cnt <= '0;
        end else if (clear || state != S_WAIT) begin
            wd_cnt <= '0;
        end else if (!wd_timeout) begin
            wd_cnt <= wd_cnt + 1'b1;
        end
    end

    assign wd_timeout = (state == S_WAIT) && !sd_done && (wd_cnt == TO_LAST);
`else
    logic [TO_W-1:0] wd_unused;
    assign wd_unused  = TO_LIMIT;
    assign wd_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            hold_op    <= '0;
            hold_mem   <= '0;
            hold_disk  <= '0;
            hold_len   <= 1'b0;
            err_status <= '0;
            write_lock <= '0;
        end else if (clear) begin
            state      <= S_IDLE;
            hold_op    <= '0;
            hold_mem   <= '0;
            hold_disk  <= '0;
            hold_len   <= 1'b0;
            err_status <= '0;
            write_lock <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && go) begin
                hold_op    <= cmd[0:2];
                hold_mem   <= {cmd[6:8], car};
                hold_disk  <= {cmd[9:10], cmd[11], dar};
                hold_len   <= cmd[5];
                err_status <= '0;
            end
            if (state == S_CHECK) begin
                err_status <= err_status | chk_err;
                if (chk_set_lock) begin
                    write_lock[drive] <= 1'b1;
                end
            end
            if (state == S_WAIT && sd_done && sd_err) begin
                err_status[ST_DRIVE] <= 1'b1;
            end
            if (wd_timeout) begin
                err_status[ST_TIMING] <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        sd_go      = 1'b0;
        busy       = 1'b0;
        done_pulse = 1'b0;
        case (state)
            S_IDLE: begin
                if (go) state_next = S_CHECK;
            end
            S_CHECK: begin
                busy       = 1'b1;
                state_next = chk_next;
            end
            S_ISSUE: begin
                busy = 1'b1;
                if (!sd_busy) begin
                    sd_go      = 1'b1;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                busy = 1'b1;
                if (sd_done || wd_timeout) state_next = S_DONE;
            end
            S_DONE: begin
                done_pulse = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign sd_op        = hold_op;
    assign sd_mem_addr  = hold_mem;
    assign sd_disk_addr = hold_disk;
    assign sd_len       = hold_len;

endmodule

// File: tb/tb_rk8e_xfer_seq.sv
// tb_rk8e_xfer_seq: directed bench for rk8e_xfer_seq. Inputs change on the
// falling edge; outputs are sampled on the falling edge.
// With RK8E_WATCHDOG_EN defined the DUT is built with TO_LIMIT=100.
module tb_rk8e_xfer_seq;

`ifdef RK8E_WATCHDOG_EN
    localparam logic [23:0] TB_TO_LIMIT = 24'd100;
    localparam int WD_SPAN = 300;
`else
    localparam logic [23:0] TB_TO_LIMIT = 24'hFFFFFF;
    localparam int WD_SPAN = 200;
`endif

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic        go;
    logic [0:11] cmd;
    logic [0:11] dar;
    logic [0:11] car;
    logic        sd_busy;
    logic        sd_done;
    logic        sd_err;
    logic        sd_go;
    logic [0:2]  sd_op;
    logic [0:14] sd_mem_addr;
    logic [0:14] sd_disk_addr;
    logic        sd_len;
    logic        busy;
    logic        done_pulse;
    logic [0:11] err_status;
    logic [0:3]  write_lock;

    int n_total = 0;
    int n_bad   = 0;
    int sd_go_cnt = 0;
    int g0;
    int seen;

    rk8e_xfer_seq #(.TO_W(24), .TO_LIMIT(TB_TO_LIMIT)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .clear        (clear),
        .go           (go),
        .cmd          (cmd),
        .dar          (dar),
        .car          (car),
        .sd_busy      (sd_busy),
        .sd_done      (sd_done),
        .sd_err       (sd_err),
        .sd_go        (sd_go),
        .sd_op        (sd_op),
        .sd_mem_addr  (sd_mem_addr),
        .sd_disk_addr (sd_disk_addr),
        .sd_len       (sd_len),
        .busy         (busy),
        .done_pulse   (done_pulse),
        .err_status   (err_status),
        .write_lock   (write_lock)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (sd_go) sd_go_cnt <= sd_go_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    // go high for one cycle; returns at the sample point of cycle N+1
    task automatic issue_go(input logic [11:0] c, input logic [11:0] d, input logic [11:0] a);
        @(negedge clk);
        cmd = c; dar = d; car = a; go = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    // called at a sample point; returns one cycle later
    task automatic pulse_done(input logic e);
        sd_done = 1'b1; sd_err = e;
        @(negedge clk);
        sd_done = 1'b0; sd_err = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset_n = 1'b0; clear = 1'b0; go = 1'b0;
        cmd = '0; dar = '0; car = '0;
        sd_busy = 1'b0; sd_done = 1'b0; sd_err = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick();

        // reset state
        check("rst_busy", busy, 0);
        check("rst_sd_go", sd_go, 0);
        check("rst_done", done_pulse, 0);
        check("rst_err", err_status, 0);
        check("rst_wlock", write_lock, 0);
        check("rst_mem", sd_mem_addr, 0);
        check("rst_disk", sd_disk_addr, 0);

        // plain read
        g0 = sd_go_cnt;
        issue_go(12'o0000, 12'o0012, 12'o0200);
        check("rd_busy_n1", busy, 1);
        check("rd_sdgo_n1", sd_go, 0);
        tick();
        check("rd_sdgo_n2", sd_go, 1);
        check("rd_op", sd_op, 0);
        check("rd_mem", sd_mem_addr, 15'o00200);
        check("rd_disk", sd_disk_addr, 15'o00012);
        check("rd_len", sd_len, 0);
        cmd = 12'o7777; dar = 12'o7777; car = 12'o7777;
        tick();
        check("rd_sdgo_once", sd_go, 0);
        check("rd_mem_held", sd_mem_addr, 15'o00200);
        go = 1'b1; cmd = 12'o6000;
        tick();
        go = 1'b0;
        tick(8);
        check("rd_busy_wait", busy, 1);
        check("rd_op_no_relatch", sd_op, 0);
        pulse_done(1'b0);
        check("rd_done", done_pulse, 1);
        check("rd_busy_done", busy, 0);
        check("rd_err", err_status, 0);
        tick();
        check("rd_done_once", done_pulse, 0);
        check("rd_sdgo_count", sd_go_cnt - g0, 1);
        pulse_done(1'b0);
        check("idle_sd_done_ignored", done_pulse, 0);

        // read-all, half sector, drive 3, engine busy, SD error
        sd_busy = 1'b1;
        issue_go(12'o1156, 12'o0123, 12'o7654);
        tick();
        check("bz_sdgo_held", sd_go, 0);
        tick(3);
        check("bz_sdgo_held2", sd_go, 0);
        check("bz_busy", busy, 1);
        sd_busy = 1'b0;
        #1;
        check("bz_sdgo", sd_go, 1);
        check("bz_op", sd_op, 1);
        check("bz_mem", sd_mem_addr, 15'o57654);
        check("bz_disk", sd_disk_addr, 15'o60123);
        check("bz_len", sd_len, 1);
        tick();
        pulse_done(1'b1);
        check("bz_done", done_pulse, 1);
        check("bz_err_drive", err_status, 12'o0002);
        tick();

        // write protect drive 1, then write to it
        g0 = sd_go_cnt;
        issue_go(12'o2002, 12'o0000, 12'o0000);
        tick();
        check("wp_done_n2", done_pulse, 1);
        check("wp_lock", write_lock, 4'b0100);
        check("wp_err_cleared", err_status, 0);
        tick();
        issue_go(12'o4002, 12'o0000, 12'o0000);
        tick();
        check("wl_done", done_pulse, 1);
        check("wl_err", err_status, 12'o0020);
        tick();
        check("wl_no_sdgo", sd_go_cnt - g0, 0);
        // write to unlocked drive 0 goes to the card
        issue_go(12'o4000, 12'o0000, 12'o0000);
        tick();
        check("wr0_sdgo", sd_go, 1);
        tick();
        pulse_done(1'b0);
        check("wr0_done", done_pulse, 1);
        check("wr0_err", err_status, 0);
        tick();

        // seek: local, no SD access
        g0 = sd_go_cnt;
        issue_go(12'o3000, 12'o0000, 12'o0000);
        tick();
        check("sk_done", done_pulse, 1);
        check("sk_err", err_status, 0);
        tick();
        check("sk_no_sdgo", sd_go_cnt - g0, 0);

        // illegal function
        issue_go(12'o6000, 12'o0000, 12'o0000);
        tick();
        check("ill_done", done_pulse, 1);
        check("ill_err", err_status, 12'o0002);
        tick();
        // cylinder error outranks illegal function (op 7, cyl 204)
        issue_go(12'o7001, 12'o4600, 12'o0000);
        tick();
        check("prio_err", err_status, 12'o0001);
        tick();

        // cylinder 204 fails, 203 passes
        g0 = sd_go_cnt;
        issue_go(12'o0001, 12'o4600, 12'o0000);
        tick();
        check("cyl204_done", done_pulse, 1);
        check("cyl204_err", err_status, 12'o0001);
        tick();
        check("cyl204_no_sdgo", sd_go_cnt - g0, 0);
        issue_go(12'o0001, 12'o4540, 12'o0000);
        tick();
        check("cyl203_sdgo", sd_go, 1);
        check("cyl203_disk", sd_disk_addr, 15'o14540);
        tick();
        pulse_done(1'b0);
        check("cyl203_err", err_status, 0);
        tick();

        // clear during WAIT
        issue_go(12'o0000, 12'o0012, 12'o0200);
        tick(2);
        check("clr_busy_before", busy, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_wlock", write_lock, 0);
        check("clr_mem", sd_mem_addr, 0);
        pulse_done(1'b0);
        check("clr_late_done", done_pulse, 0);
        check("clr_late_busy", busy, 0);

        // go and clear together: clear wins
        @(negedge clk);
        cmd = 12'o0000; go = 1'b1; clear = 1'b1;
        tick();
        go = 1'b0; clear = 1'b0;
        check("goclr_busy", busy, 0);
        tick();
        check("goclr_sdgo", sd_go, 0);

        // asynchronous reset mid-WAIT
        issue_go(12'o2000, 12'o0000, 12'o0000);
        tick(2);
        check("ar_lock_set", write_lock, 4'b1000);
        issue_go(12'o0000, 12'o0012, 12'o0200);
        tick(2);
        check("ar_busy_before", busy, 1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_busy", busy, 0);
        check("ar_mem", sd_mem_addr, 0);
        check("ar_wlock", write_lock, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // watchdog / indefinite wait
        issue_go(12'o0000, 12'o0012, 12'o0200);
        tick();
        check("wd_sdgo", sd_go, 1);
        seen = 0;
        for (int k = 1; k <= WD_SPAN; k++) begin
            tick();
            if (done_pulse && seen == 0) begin
                seen = k;
`ifdef RK8E_WATCHDOG_EN
                check("wd_err_timing", err_status, 12'o0040);
`endif
            end
            if (seen != 0) break;
        end
`ifdef RK8E_WATCHDOG_EN
        check("wd_latency", seen, 101);
`else
        check("wd_no_done", seen, 0);
        check("wd_still_busy", busy, 1);
        pulse_done(1'b0);
        check("wd_late_done", done_pulse, 1);
        check("wd_err", err_status, 0);
`endif
        tick(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
